hub75_fb_arbiter: RTL

//  Shares the single framebuffer write port of the HUB75 panel driver between two requesters.

---
 rtl/hub75_fb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hub75_fb_arbiter.sv
// Two-requester write arbiter for the HUB75 framebuffer back buffer, with frame-aligned buffer swap.
// Optional saturating activity counters are compiled in when HUB75_ARB_STATS_EN is defined.
module hub75_fb_arbiter #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_wmask,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_wmask,
  input  logic              m1_last,
  output logic              m1_ack,
  input  logic              swap_req,
  input  logic              frame_end,
`ifdef HUB75_ARB_STATS_EN
  output logic [15:0]       stat_m0_beats,
  output logic [15:0]       stat_m1_beats,
  output logic [15:0]       stat_swaps,
`endif
  output logic              fb_wen,
  output logic [ADDR_W:0]   fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic [2:0]        fb_wmask,
  output logic              front_sel,
  output logic              swap_pending
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_e              state_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                front_q;
  logic                pend_q;
  logic                fb_wen_q;
  logic [ADDR_W:0]     fb_addr_q;
  logic [DATA_W-1:0]   fb_wdata_q;
  logic [2:0]          fb_wmask_q;
  logic                swap_take;
  logic                burst_done;

  always_comb begin
    m0_ack     = (state_q == GNT0) & m0_req;
    m1_ack     = (state_q == GNT1) & m1_req;
    // A swap only lands when nothing is granted or in flight, so no burst can straddle buffers.
    swap_take  = frame_end & (pend_q | swap_req) & (state_q == IDLE) & ~fb_wen_q;
    cnt_d      = cnt_q + CNT_W'(1);
    burst_done = m1_last | (cnt_d == CNT_W'(MAX_BURST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      front_q      <= 1'b0;
      pend_q       <= 1'b0;
      fb_wen_q     <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      fb_wmask_q   <= '0;
    end else begin
      fb_wen_q <= m0_ack | m1_ack;
      if (m0_ack) begin
        fb_addr_q  <= {~front_q, m0_addr};
        fb_wdata_q <= m0_wdata;
        fb_wmask_q <= m0_wmask;
      end else if (m1_ack) begin
        fb_addr_q  <= {~front_q, m1_addr};
        fb_wdata_q <= m1_wdata;
        fb_wmask_q <= m1_wmask;
      end

      if (swap_take) begin
        front_q <= ~front_q;
        pend_q  <= 1'b0;
      end else if (swap_req) begin
        pend_q  <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!swap_take) begin
            if (m0_req && m1_req) state_q <= last_grant_q ? GNT0 : GNT1;
            else if (m0_req)      state_q <= GNT0;
            else if (m1_req)      state_q <= GNT1;
          end
        end
        GNT0: begin
          state_q <= IDLE;
          if (m0_req) last_grant_q <= 1'b0;
        end
        GNT1: begin
          if (!m1_req) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (burst_done) begin
              state_q      <= IDLE;
              last_grant_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_wen       = fb_wen_q;
  assign fb_addr      = fb_addr_q;
  assign fb_wdata     = fb_wdata_q;
  assign fb_wmask     = fb_wmask_q;
  assign front_sel    = front_q;
  assign swap_pending = pend_q;

`ifdef HUB75_ARB_STATS_EN
  logic [15:0] st_m0_q, st_m1_q, st_sw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_m0_q <= '0;
      st_m1_q <= '0;
      st_sw_q <= '0;
    end else begin
      if (m0_ack && st_m0_q != '1)    st_m0_q <= st_m0_q + 16'd1;
      if (m1_ack && st_m1_q != '1)    st_m1_q <= st_m1_q + 16'd1;
      if (swap_take && st_sw_q != '1) st_sw_q <= st_sw_q + 16'd1;
    end
  end

  assign stat_m0_beats = st_m0_q;
  assign stat_m1_beats = st_m1_q;
  assign stat_swaps    = st_sw_q;
`endif

endmodule
